// File: rtl/signed_sar_search.sv
// signed_sar_search
//
// Binary-search initiator for a signed comparator responder. It finds a hidden signed
// two's-complement value by presenting guesses on o_guess and narrowing its [lo, hi] window
// from the responder's greater/equal/less verdict. It reports the found value, the number
// of responses consumed, or an error if the responder is inconsistent or answers illegally.
//
// Ports
//   clk            : single clock, rising edge
//   rst_n          : asynchronous active-low reset
//   i_start        : request a new search (sampled only while idle)
//   o_guess        : current probe value B, signed
//   o_guess_valid  : o_guess is presented and awaiting a response
//   i_resp_valid   : responder verdict valid this cycle (ignored unless o_guess_valid)
//   i_a_greater_b  : target > guess
//   i_a_equal_b    : target == guess
//   i_a_less_b     : target < guess
//   o_busy         : search in progress
//   o_done         : one-cycle completion pulse
//   o_result       : found value, held until the next start
//   o_err          : bad response or inconsistent responder, held until the next start
//   o_probes       : responses consumed in the last or current search
//
// All outputs are registered; nothing flows combinationally from inputs to outputs.

module signed_sar_search #(
  parameter int unsigned Bits = 4,
  localparam int unsigned ProbeW = $clog2(Bits + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  output logic [Bits-1:0]   o_guess,
  output logic              o_guess_valid,
  input  logic              i_resp_valid,
  input  logic              i_a_greater_b,
  input  logic              i_a_equal_b,
  input  logic              i_a_less_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [Bits-1:0]   o_result,
  output logic              o_err,
  output logic [ProbeW-1:0] o_probes
);

  // Bounds are one bit wider than the operand so hi+1 / lo-1 at the range edges stay exact.
  localparam logic signed [Bits:0] LoInit = {2'b11, {(Bits - 1){1'b0}}};
  localparam logic signed [Bits:0] HiInit = {2'b00, {(Bits - 1){1'b1}}};
  localparam logic signed [Bits:0] One    = {{Bits{1'b0}}, 1'b1};
  localparam logic [ProbeW-1:0]    ProbeOne = {{(ProbeW - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StProbe,
    StFin
  } state_e;

  // Verdict encodings as {greater, equal, less}
  localparam logic [2:0] VerdGt = 3'b100;
  localparam logic [2:0] VerdEq = 3'b010;
  localparam logic [2:0] VerdLt = 3'b001;

  state_e r_state;
  state_e w_state_next;

  logic signed [Bits:0] r_lo;
  logic signed [Bits:0] r_hi;
  logic [Bits-1:0]      r_guess;
  logic [Bits-1:0]      r_result;
  logic                 r_err;
  logic [ProbeW-1:0]    r_probes;
  logic                 r_busy;
  logic                 r_guess_valid;
  logic                 r_done;

  logic signed [Bits:0] w_lo_d;
  logic signed [Bits:0] w_hi_d;
  logic [Bits-1:0]      w_guess_d;
  logic [Bits-1:0]      w_result_d;
  logic                 w_err_d;
  logic [ProbeW-1:0]    w_probes_d;
  logic                 w_busy_d;
  logic                 w_guess_valid_d;
  logic                 w_done_d;

  logic signed [Bits:0] w_sum;
  logic [Bits-1:0]      w_mid;
  logic                 w_unused_sum_lsb;
  logic signed [Bits:0] w_guess_ext;
  logic                 w_lo_gt_hi;
  logic [2:0]           w_verdict;
  logic                 w_verdict_step;

  // mid = (lo + hi) >>> 1 truncated to Bits. Bits [Bits:1] of the (Bits+1)-wide sum are that
  // value even when the sum wraps, because wrap-around only disturbs bits above Bits.
  assign w_sum            = r_lo + r_hi;
  assign w_mid            = w_sum[Bits:1];
  assign w_unused_sum_lsb = w_sum[0];

  assign w_guess_ext    = $signed({r_guess[Bits-1], r_guess});
  assign w_lo_gt_hi     = r_lo > r_hi;
  assign w_verdict      = {i_a_greater_b, i_a_equal_b, i_a_less_b};
  assign w_verdict_step = (w_verdict == VerdGt) || (w_verdict == VerdLt);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = StCalc;
        end
      end
      StCalc: begin
        // An inconsistent responder eventually empties the window.
        w_state_next = w_lo_gt_hi ? StFin : StProbe;
      end
      StProbe: begin
        if (i_resp_valid) begin
          w_state_next = w_verdict_step ? StCalc : StFin;
        end
      end
      StFin: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    w_lo_d     = r_lo;
    w_hi_d     = r_hi;
    w_guess_d  = r_guess;
    w_result_d = r_result;
    w_err_d    = r_err;
    w_probes_d = r_probes;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_lo_d     = LoInit;
          w_hi_d     = HiInit;
          w_probes_d = '0;
          w_err_d    = 1'b0;
          w_result_d = '0;
        end
      end
      StCalc: begin
        if (w_lo_gt_hi) begin
          w_err_d = 1'b1;
        end else begin
          w_guess_d = w_mid;
        end
      end
      StProbe: begin
        if (i_resp_valid) begin
          w_probes_d = r_probes + ProbeOne;
          case (w_verdict)
            VerdEq: w_result_d = r_guess;
            VerdGt: w_lo_d     = w_guess_ext + One;
            VerdLt: w_hi_d     = w_guess_ext - One;
            default: begin
              w_err_d    = 1'b1;
              w_result_d = '0;
            end
          endcase
        end
      end
      StFin: begin
      end
      default: begin
      end
    endcase

    // Status flags are registered copies of the upcoming state so they align with it.
    w_busy_d        = (w_state_next != StIdle);
    w_guess_valid_d = (w_state_next == StProbe);
    w_done_d        = (w_state_next == StFin);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo          <= '0;
      r_hi          <= '0;
      r_guess       <= '0;
      r_result      <= '0;
      r_err         <= 1'b0;
      r_probes      <= '0;
      r_busy        <= 1'b0;
      r_guess_valid <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_lo          <= w_lo_d;
      r_hi          <= w_hi_d;
      r_guess       <= w_guess_d;
      r_result      <= w_result_d;
      r_err         <= w_err_d;
      r_probes      <= w_probes_d;
      r_busy        <= w_busy_d;
      r_guess_valid <= w_guess_valid_d;
      r_done        <= w_done_d;
    end
  end

  assign o_guess       = r_guess;
  assign o_guess_valid = r_guess_valid;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_result      = r_result;
  assign o_err         = r_err;
  assign o_probes      = r_probes;

endmodule
